// File: rtl/parity_frame_rx_pkg.sv
// ----------------------------------------------------------------------------
// parity_frame_rx_pkg
// Shared definitions for the parity-protected serial frame receiver.
//   state_t    : receiver FSM state encoding (2 bits)
//   cnt_width(): width of the data-bit counter for a given frame data width
// ----------------------------------------------------------------------------
package parity_frame_rx_pkg;

    // Receiver FSM states. The encodings are fixed so that other blocks
    // on the link can decode the state from a probe if needed.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    // Counter width that holds 0 .. w-1. A width of at least 1 keeps the
    // counter well formed even for degenerate widths.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage : parity_frame_rx_pkg

// File: rtl/frame_bit_counter.sv
// ----------------------------------------------------------------------------
// frame_bit_counter
// Counts data bits within one frame.
// Ports:
//   clk     in   1   clock, rising edge
//   reset   in   1   asynchronous, active-high reset (count -> 0)
//   clear   in   1   restart the count at 0 (start bit accepted)
//   enable  in   1   one data bit is being sampled this cycle
//   last    out  1   the bit being sampled now is the DATA_W-th data bit
// ----------------------------------------------------------------------------
module frame_bit_counter
    import parity_frame_rx_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic last
);

    localparam int CNT_W = cnt_width(DATA_W);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_W - 1);

    logic [CNT_W-1:0] count_reg;

    // The count saturates at the last index rather than wrapping; the FSM
    // leaves the data phase on that bit, and the next start bit clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable && (count_reg != LAST_IDX)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign last = (count_reg == LAST_IDX);

endmodule : frame_bit_counter

// File: rtl/parity_frame_rx.sv
// ----------------------------------------------------------------------------
// parity_frame_rx
// Serial receiver for frames of the form
//   start(0), DATA_W data bits LSB first, parity bit, stop(1).
// Recomputes XOR parity over the data, compares it with the received parity
// bit and reports the data word together with parity and framing errors.
// One line bit is consumed per clock cycle with in_valid=1.
// Ports:
//   clk         in   1       clock, rising edge
//   reset       in   1       asynchronous, active-high reset
//   in_valid    in   1       in_bit is sampled this cycle (0 = hold state)
//   in_bit      in   1       serial line bit, idles at 1
//   data_out    out  DATA_W  data of the last completed frame (held)
//   data_valid  out  1       one-cycle pulse: a frame completed
//   parity_err  out  1       with data_valid: parity mismatch
//   frame_err   out  1       with data_valid: stop bit was 0
//   busy        out  1       receiver is inside a frame
// ----------------------------------------------------------------------------
module parity_frame_rx
    import parity_frame_rx_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter bit ODD_PARITY = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic              in_bit,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy
);

    state_t              state_reg;
    logic [DATA_W-1:0]   shift_reg;
    logic                acc_reg;        // running XOR of data bits (seeded)
    logic                perr_reg;       // parity verdict, held until stop
    logic [DATA_W-1:0]   data_out_reg;
    logic                data_valid_reg;
    logic                parity_err_reg;
    logic                frame_err_reg;

    logic                cnt_clear;
    logic                cnt_enable;
    logic                cnt_last;

    // A start bit restarts the count; every sampled data bit advances it.
    assign cnt_clear  = in_valid && (state_reg == ST_IDLE) && !in_bit;
    assign cnt_enable = in_valid && (state_reg == ST_DATA);

    frame_bit_counter #(
        .DATA_W (DATA_W)
    ) u_bit_counter (
        .clk    (clk),
        .reset  (reset),
        .clear  (cnt_clear),
        .enable (cnt_enable),
        .last   (cnt_last)
    );

    // Receiver FSM with registered outputs. The pulse outputs default low
    // every cycle, so a stalled cycle (in_valid=0) never repeats a pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            shift_reg      <= '0;
            acc_reg        <= 1'b0;
            perr_reg       <= 1'b0;
            data_out_reg   <= '0;
            data_valid_reg <= 1'b0;
            parity_err_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
        end else begin
            data_valid_reg <= 1'b0;
            parity_err_reg <= 1'b0;
            frame_err_reg  <= 1'b0;

            if (in_valid) begin
                case (state_reg)
                    ST_IDLE: begin
                        if (!in_bit) begin
                            state_reg <= ST_DATA;
                            // Seeding with ODD_PARITY makes a zero final
                            // verdict mean "parity good" for either mode.
                            acc_reg   <= ODD_PARITY;
                        end
                    end

                    ST_DATA: begin
                        // LSB arrives first: shift right, insert at MSB so
                        // the first bit lands in bit 0 after DATA_W shifts.
                        shift_reg <= {in_bit, shift_reg[DATA_W-1:1]};
                        acc_reg   <= acc_reg ^ in_bit;
                        if (cnt_last) begin
                            state_reg <= ST_PARITY;
                        end
                    end

                    ST_PARITY: begin
                        perr_reg  <= acc_reg ^ in_bit;
                        state_reg <= ST_STOP;
                    end

                    ST_STOP: begin
                        // The frame is delivered even when damaged; a 0 stop
                        // bit goes straight back to IDLE and is not taken as
                        // the next start bit.
                        data_out_reg   <= shift_reg;
                        parity_err_reg <= perr_reg;
                        frame_err_reg  <= ~in_bit;
                        data_valid_reg <= 1'b1;
                        state_reg      <= ST_IDLE;
                    end

                    default: begin
                        state_reg <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign data_out   = data_out_reg;
    assign data_valid = data_valid_reg;
    assign parity_err = parity_err_reg;
    assign frame_err  = frame_err_reg;
    assign busy       = (state_reg != ST_IDLE);

endmodule : parity_frame_rx

// File: tb/tb_parity_frame_rx.sv
// ----------------------------------------------------------------------------
// tb_parity_frame_rx
// Self-checking bench for parity_frame_rx (DATA_W=8, even parity).
// Frames are built from their data/parity/stop values; expected results
// come from a parity/stop model evaluated on those values.
// ----------------------------------------------------------------------------
module tb_parity_frame_rx;

    localparam int DATA_W = 8;
    localparam bit ODD    = 1'b0;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic              in_bit;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              parity_err;
    logic              frame_err;
    logic              busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        logic [DATA_W-1:0] d;
        logic              pe;
        logic              fe;
        int                cyc;
    } pulse_t;

    pulse_t mon_q[$];
    pulse_t exp_q[$];

    parity_frame_rx #(
        .DATA_W     (DATA_W),
        .ODD_PARITY (ODD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_bit     (in_bit),
        .data_out   (data_out),
        .data_valid (data_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every completed-frame pulse with the cycle it appeared in.
    always @(negedge clk) begin
        if (data_valid === 1'b1) begin
            mon_q.push_back('{d: data_out, pe: parity_err, fe: frame_err, cyc: cyc});
        end
    end

    // Reference model: parity of data plus parity bit must equal the mode.
    function automatic logic model_perr(input logic [DATA_W-1:0] d, input logic par);
        return ((($countones(d) + int'(par)) % 2) != int'(ODD));
    endfunction

    task automatic drive_bit(input logic b, input int stall);
        for (int s = 0; s < stall; s++) begin
            in_valid = 1'b0;
            in_bit   = logic'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_bit   = b;
        @(posedge clk); #1;
    endtask

    // Sends one full frame; stall_len idle-valid cycles are inserted before
    // data bit stall_at, or random stalls everywhere when rand_stalls is set.
    task automatic send_frame(input logic [DATA_W-1:0] d, input logic par, input logic stop,
                              input int stall_at, input int stall_len, input bit rand_stalls);
        int st;
        st = (rand_stalls && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
        drive_bit(1'b0, st);
        for (int i = 0; i < DATA_W; i++) begin
            st = (i == stall_at) ? stall_len : 0;
            if (rand_stalls && $urandom_range(0, 3) == 0) st = int'($urandom_range(1, 3));
            drive_bit(d[i], st);
        end
        st = (rand_stalls && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
        drive_bit(par, st);
        st = (rand_stalls && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
        drive_bit(stop, st);
        in_bit = 1'b1;
    endtask

    task automatic test_reset();
        #3;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy actual=%b required=0", busy); end
        n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dv actual=%b required=0", data_valid); end
        n_checks++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data actual=%h required=00", data_out); end
        n_checks++; if ({parity_err, frame_err} !== 2'b00) begin n_fail++; $display("FAIL reset_errs actual=%b required=00", {parity_err, frame_err}); end
        @(posedge clk); #1;
        reset = 1'b0;
        in_valid = 1'b1;
        in_bit = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy actual=%b required=0", busy); end
        $display("test_reset done");
    endtask

    task automatic test_good_frame();
        int c0;
        mon_q.delete();
        c0 = cyc;
        send_frame(8'hA5, 1'b0, 1'b1, -1, 0, 1'b0);
        n_checks++; if (data_valid !== 1'b1) begin n_fail++; $display("FAIL good_dv actual=%b required=1", data_valid); end
        n_checks++; if (data_out !== 8'hA5) begin n_fail++; $display("FAIL good_data actual=%h required=a5", data_out); end
        n_checks++; if ({parity_err, frame_err} !== 2'b00) begin n_fail++; $display("FAIL good_errs actual=%b required=00", {parity_err, frame_err}); end
        @(posedge clk); #1;
        n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL good_pulse_width actual=%b required=0", data_valid); end
        n_checks++; if (data_out !== 8'hA5) begin n_fail++; $display("FAIL good_data_held actual=%h required=a5", data_out); end
        n_checks++; if (mon_q.size() !== 1) begin n_fail++; $display("FAIL good_pulse_count actual=%0d required=1", mon_q.size()); end
        else begin
            n_checks++; if (mon_q[0].cyc !== c0 + 11) begin n_fail++; $display("FAIL good_latency actual=%0d required=%0d", mon_q[0].cyc - c0, 11); end
        end
        $display("test_good_frame data=%h perr=%b ferr=%b", 8'hA5, 1'b0, 1'b0);
    endtask

    task automatic test_parity_error();
        send_frame(8'hA5, 1'b1, 1'b1, -1, 0, 1'b0);
        n_checks++; if (data_valid !== 1'b1) begin n_fail++; $display("FAIL perr_dv actual=%b required=1", data_valid); end
        n_checks++; if (data_out !== 8'hA5) begin n_fail++; $display("FAIL perr_data actual=%h required=a5", data_out); end
        n_checks++; if ({parity_err, frame_err} !== 2'b10) begin n_fail++; $display("FAIL perr_errs actual=%b required=10", {parity_err, frame_err}); end
        @(posedge clk); #1;
        $display("test_parity_error data=%h perr=1 ferr=0", 8'hA5);
    endtask

    task automatic test_frame_error();
        send_frame(8'hA5, 1'b0, 1'b0, -1, 0, 1'b0);
        n_checks++; if (data_valid !== 1'b1) begin n_fail++; $display("FAIL ferr_dv actual=%b required=1", data_valid); end
        n_checks++; if ({parity_err, frame_err} !== 2'b01) begin n_fail++; $display("FAIL ferr_errs actual=%b required=01", {parity_err, frame_err}); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ferr_busy actual=%b required=0", busy); end
        @(posedge clk); #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ferr_busy_next actual=%b required=0", busy); end
        n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL ferr_dv_next actual=%b required=0", data_valid); end
        $display("test_frame_error data=%h perr=0 ferr=1", 8'hA5);
    endtask

    task automatic test_stall();
        int c0;
        mon_q.delete();
        c0 = cyc;
        send_frame(8'hA5, 1'b0, 1'b1, 4, 3, 1'b0);
        n_checks++; if (data_valid !== 1'b1) begin n_fail++; $display("FAIL stall_dv actual=%b required=1", data_valid); end
        n_checks++; if (data_out !== 8'hA5) begin n_fail++; $display("FAIL stall_data actual=%h required=a5", data_out); end
        n_checks++; if ({parity_err, frame_err} !== 2'b00) begin n_fail++; $display("FAIL stall_errs actual=%b required=00", {parity_err, frame_err}); end
        @(posedge clk); #1;
        n_checks++; if (mon_q.size() !== 1) begin n_fail++; $display("FAIL stall_pulse_count actual=%0d required=1", mon_q.size()); end
        else begin
            n_checks++; if (mon_q[0].cyc !== c0 + 14) begin n_fail++; $display("FAIL stall_latency actual=%0d required=14", mon_q[0].cyc - c0); end
        end
        $display("test_stall data=%h stall=3", 8'hA5);
    endtask

    task automatic test_reset_mid_frame();
        logic [DATA_W-1:0] d;
        d = 8'h5A;
        mon_q.delete();
        drive_bit(1'b0, 0);
        for (int i = 0; i < 4; i++) drive_bit(d[i], 0);
        #2 reset = 1'b1;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy actual=%b required=0", busy); end
        n_checks++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL midrst_data actual=%h required=00", data_out); end
        n_checks++; if ({data_valid, parity_err, frame_err} !== 3'b000) begin n_fail++; $display("FAIL midrst_flags actual=%b required=000", {data_valid, parity_err, frame_err}); end
        @(posedge clk); #1;
        reset  = 1'b0;
        in_bit = 1'b1;
        @(posedge clk); #1;
        send_frame(8'h3C, 1'b0, 1'b1, -1, 0, 1'b0);
        n_checks++; if (data_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_dv actual=%b required=1", data_valid); end
        n_checks++; if (data_out !== 8'h3C) begin n_fail++; $display("FAIL midrst_next_data actual=%h required=3c", data_out); end
        n_checks++; if ({parity_err, frame_err} !== 2'b00) begin n_fail++; $display("FAIL midrst_errs actual=%b required=00", {parity_err, frame_err}); end
        @(posedge clk); #1;
        n_checks++; if (mon_q.size() !== 1) begin n_fail++; $display("FAIL midrst_pulse_count actual=%0d required=1", mon_q.size()); end
        $display("test_reset_mid_frame then data=%h", 8'h3C);
    endtask

    task automatic test_back_to_back();
        mon_q.delete();
        send_frame(8'hFF, 1'b0, 1'b1, -1, 0, 1'b0);
        send_frame(8'h01, 1'b1, 1'b1, -1, 0, 1'b0);
        @(posedge clk); #1;
        n_checks++; if (mon_q.size() !== 2) begin n_fail++; $display("FAIL b2b_pulse_count actual=%0d required=2", mon_q.size()); end
        else begin
            n_checks++; if (mon_q[1].cyc - mon_q[0].cyc !== 11) begin n_fail++; $display("FAIL b2b_spacing actual=%0d required=11", mon_q[1].cyc - mon_q[0].cyc); end
            n_checks++; if (mon_q[0].d !== 8'hFF) begin n_fail++; $display("FAIL b2b_data0 actual=%h required=ff", mon_q[0].d); end
            n_checks++; if (mon_q[1].d !== 8'h01) begin n_fail++; $display("FAIL b2b_data1 actual=%h required=01", mon_q[1].d); end
            n_checks++; if ({mon_q[0].pe, mon_q[0].fe, mon_q[1].pe, mon_q[1].fe} !== 4'b0000) begin n_fail++; $display("FAIL b2b_errs actual=%b required=0000", {mon_q[0].pe, mon_q[0].fe, mon_q[1].pe, mon_q[1].fe}); end
        end
        $display("test_back_to_back data=ff,01");
    endtask

    task automatic test_random();
        logic [DATA_W-1:0] d;
        logic par, stop;
        int gap;
        mon_q.delete();
        exp_q.delete();
        for (int f = 0; f < 40; f++) begin
            d    = DATA_W'($urandom);
            par  = logic'($urandom_range(0, 1));
            stop = ($urandom_range(0, 4) != 0);
            exp_q.push_back('{d: d, pe: model_perr(d, par), fe: ~stop, cyc: 0});
            send_frame(d, par, stop, -1, 0, 1'b1);
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) drive_bit(1'b1, 0);
        end
        repeat (2) begin @(posedge clk); #1; end
        n_checks++; if (mon_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL rand_pulse_count actual=%0d required=%0d", mon_q.size(), exp_q.size()); end
        else begin
            for (int k = 0; k < exp_q.size(); k++) begin
                n_checks++;
                if ({mon_q[k].d, mon_q[k].pe, mon_q[k].fe} !== {exp_q[k].d, exp_q[k].pe, exp_q[k].fe}) begin
                    n_fail++;
                    $display("FAIL rand_frame%0d actual=%h/%b/%b required=%h/%b/%b", k,
                             mon_q[k].d, mon_q[k].pe, mon_q[k].fe, exp_q[k].d, exp_q[k].pe, exp_q[k].fe);
                end else begin
                    $display("rand frame %0d data=%h perr=%b ferr=%b", k, mon_q[k].d, mon_q[k].pe, mon_q[k].fe);
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_bit   = 1'b1;
        test_reset();
        test_good_frame();
        test_parity_error();
        test_frame_error();
        test_stall();
        test_reset_mid_frame();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_parity_frame_rx
